// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - gshare branch predictor with speculative history, perf counters, optional BTB (BPU_BTB_EN)
module branch_predictor_unit #(
    parameter int PC_W      = 6,
    parameter int IDX_W     = 6,
    parameter int GHR_W     = 4,
    parameter int CTR_W     = 2,
    parameter int BTB_IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             lookup_valid_i,
    input  logic [PC_W-1:0]  lookup_pc_i,
    output logic             pred_taken_o,
    output logic [PC_W-1:0]  pred_target_o,
    output logic             pred_btb_hit_o,
    output logic [GHR_W-1:0] pred_ghr_o,
    input  logic             update_valid_i,
    input  logic [PC_W-1:0]  update_pc_i,
    input  logic [GHR_W-1:0] update_ghr_i,
    input  logic             update_taken_i,
    input  logic             update_pred_i,
    input  logic [PC_W-1:0]  update_target_i,
    output logic             mispredict_o,
    output logic [15:0]      branch_count_o,
    output logic [15:0]      mispredict_count_o
);

    localparam int PHT_N = 1 << IDX_W;
    localparam int EXT_W = (PC_W > IDX_W) ? PC_W : IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CTR_W-1:0] pht_q [PHT_N];
    logic [15:0]      branch_count_q, mispredict_count_q;

    logic [IDX_W-1:0] lookup_idx, update_idx;
    logic             ctr_msb;
    logic             is_branch;
    logic             pred_taken;
    logic             mispredict;
    logic [GHR_W-1:0] ghr_recovered, ghr_shifted;

    // Zero-extend both operands to the PHT index width before hashing.
    function automatic logic [IDX_W-1:0] pht_index(input logic [PC_W-1:0] pc,
                                                   input logic [GHR_W-1:0] ghr);
        logic [EXT_W-1:0] pc_ext;
        logic [IDX_W-1:0] ghr_ext;
        pc_ext              = '0;
        pc_ext[PC_W-1:0]    = pc;
        ghr_ext             = '0;
        ghr_ext[GHR_W-1:0]  = ghr;
        return pc_ext[IDX_W-1:0] ^ ghr_ext;
    endfunction

    assign lookup_idx = pht_index(lookup_pc_i, ghr_q);
    assign update_idx = pht_index(update_pc_i, update_ghr_i);
    assign ctr_msb    = pht_q[lookup_idx][CTR_W-1];
    assign mispredict = update_valid_i & (update_taken_i != update_pred_i);

`ifdef BPU_BTB_EN
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = PC_W - BTB_IDX_W;

    logic              btb_valid_q  [BTB_N];
    logic [TAG_W-1:0]  btb_tag_q    [BTB_N];
    logic [PC_W-1:0]   btb_target_q [BTB_N];
    logic [BTB_IDX_W-1:0] btb_lk_idx, btb_up_idx;
    logic              btb_hit;

    assign btb_lk_idx = lookup_pc_i[BTB_IDX_W-1:0];
    assign btb_up_idx = update_pc_i[BTB_IDX_W-1:0];
    assign btb_hit    = btb_valid_q[btb_lk_idx] &&
                        (btb_tag_q[btb_lk_idx] == lookup_pc_i[PC_W-1:BTB_IDX_W]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_N; i++) btb_valid_q[i] <= 1'b0;
        end else if (update_valid_i && update_taken_i) begin
            btb_valid_q[btb_up_idx] <= 1'b1;
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && update_valid_i && update_taken_i) begin
            btb_tag_q[btb_up_idx]    <= update_pc_i[PC_W-1:BTB_IDX_W];
            btb_target_q[btb_up_idx] <= update_target_i;
        end
    end

    assign pred_btb_hit_o = btb_hit;
    assign pred_target_o  = btb_hit ? btb_target_q[btb_lk_idx] : '0;
    assign pred_taken     = btb_hit & ctr_msb;
    assign is_branch      = btb_hit;
`else
    logic unused_btb;
    assign unused_btb     = ^{update_target_i, BTB_IDX_W[0]};
    assign pred_btb_hit_o = 1'b0;
    assign pred_target_o  = '0;
    assign pred_taken     = ctr_msb;
    assign is_branch      = 1'b1;
`endif

    generate
        if (GHR_W == 1) begin : g_ghr1
            assign ghr_recovered = update_taken_i;
            assign ghr_shifted   = pred_taken;
        end else begin : g_ghrn
            assign ghr_recovered = {update_ghr_i[GHR_W-2:0], update_taken_i};
            assign ghr_shifted   = {ghr_q[GHR_W-2:0], pred_taken};
        end
    endgenerate

    always_comb begin
        ghr_d = ghr_q;
        if (mispredict)
            ghr_d = ghr_recovered;
        else if (lookup_valid_i && !stall_i && is_branch)
            ghr_d = ghr_shifted;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ghr_q <= '0;
        else         ghr_q <= ghr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
        end else if (update_valid_i) begin
            if (update_taken_i && pht_q[update_idx] != CTR_MAX)
                pht_q[update_idx] <= pht_q[update_idx] + 1'b1;
            else if (!update_taken_i && pht_q[update_idx] != '0)
                pht_q[update_idx] <= pht_q[update_idx] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (update_valid_i && branch_count_q != 16'hFFFF)
                branch_count_q <= branch_count_q + 16'd1;
            if (mispredict && mispredict_count_q != 16'hFFFF)
                mispredict_count_q <= mispredict_count_q + 16'd1;
        end
    end

    assign pred_taken_o       = pred_taken;
    assign pred_ghr_o         = ghr_q;
    assign mispredict_o       = mispredict;
    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - directed self-checking bench for branch_predictor_unit
module tb_branch_predictor_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [5:0]  lookup_pc = '0;
    logic        pred_taken;
    logic [5:0]  pred_target;
    logic        pred_btb_hit;
    logic [3:0]  pred_ghr;
    logic        update_valid = 1'b0;
    logic [5:0]  update_pc = '0;
    logic [3:0]  update_ghr = '0;
    logic        update_taken = 1'b0;
    logic        update_pred = 1'b0;
    logic [5:0]  update_target = '0;
    logic        mispredict;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    branch_predictor_unit dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .stall_i            (stall),
        .lookup_valid_i     (lookup_valid),
        .lookup_pc_i        (lookup_pc),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .pred_btb_hit_o     (pred_btb_hit),
        .pred_ghr_o         (pred_ghr),
        .update_valid_i     (update_valid),
        .update_pc_i        (update_pc),
        .update_ghr_i       (update_ghr),
        .update_taken_i     (update_taken),
        .update_pred_i      (update_pred),
        .update_target_i    (update_target),
        .mispredict_o       (mispredict),
        .branch_count_o     (branch_count),
        .mispredict_count_o (mispredict_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_update(input logic [5:0] pc, input logic [3:0] ghr,
                              input logic taken, input logic pred);
        update_valid = 1'b1;
        update_pc    = pc;
        update_ghr   = ghr;
        update_taken = taken;
        update_pred  = pred;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++;
        if (pred_ghr !== 4'd0 || branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: ghr=%h bc=%h mc=%h required 0/0/0", pred_ghr, branch_count, mispredict_count);
        end
        n_cmp++;
        if (pred_btb_hit !== 1'b0 || pred_target !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_btb: hit=%b target=%h required 0/0", pred_btb_hit, pred_target);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 64; i += 7) begin
            lookup_pc = 6'(i);
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0 || pred_ghr !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_lookup pc=%0d: taken=%b ghr=%h required 0/0", i, pred_taken, pred_ghr);
            end
        end
    endtask

    task automatic test_training;
        logic exp_taken [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_update(6'd5, 4'd0, (i < 4), (i < 4));
            tick;
            update_valid = 1'b0;
            lookup_pc = 6'd5;
            #1;
            n_cmp++;
            if (pred_taken !== exp_taken[i]) begin
                n_fail++;
                $display("FAIL training step %0d: taken=%b required %b", i, pred_taken, exp_taken[i]);
            end
        end
        n_cmp++;
        if (branch_count !== 16'd6 || mispredict_count !== 16'd0 || pred_ghr !== 4'd0) begin
            n_fail++;
            $display("FAIL training_counts: bc=%0d mc=%0d ghr=%h required 6/0/0", branch_count, mispredict_count, pred_ghr);
        end
    endtask

    task automatic test_mispredict;
        set_update(6'h20, 4'b0101, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (mispredict !== 1'b1) begin
            n_fail++;
            $display("FAIL misp_setup_flag: mispredict=%b required 1", mispredict);
        end
        tick;
        update_valid = 1'b0;
        #1;
        n_cmp++;
        if (pred_ghr !== 4'b1011) begin
            n_fail++;
            $display("FAIL misp_setup_ghr: ghr=%b required 1011", pred_ghr);
        end
        set_update(6'h30, 4'b0110, 1'b1, 1'b0);
        lookup_valid = 1'b1;
        lookup_pc = 6'h28;
        #1;
        n_cmp++;
        if (mispredict !== 1'b1 || pred_ghr !== 4'b1011 || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL misp_same_cycle: misp=%b ghr=%b taken=%b required 1/1011/0", mispredict, pred_ghr, pred_taken);
        end
        tick;
        update_valid = 1'b0;
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if (pred_ghr !== 4'b1101 || mispredict !== 1'b0 || pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL misp_recovered: ghr=%b misp=%b taken=%b required 1101/0/1", pred_ghr, mispredict, pred_taken);
        end
        n_cmp++;
        if (branch_count !== 16'd8 || mispredict_count !== 16'd2) begin
            n_fail++;
            $display("FAIL misp_counts: bc=%0d mc=%0d required 8/2", branch_count, mispredict_count);
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc = 6'h1D;
        set_update(6'h10, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick;
        update_valid = 1'b0;
        stall = 1'b0;
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if (pred_ghr !== 4'b1101) begin
            n_fail++;
            $display("FAIL stall_ghr: ghr=%b required 1101", pred_ghr);
        end
        n_cmp++;
        if (pred_taken !== 1'b1 || branch_count !== 16'd11) begin
            n_fail++;
            $display("FAIL stall_training: taken=%b bc=%0d required 1/11", pred_taken, branch_count);
        end
    endtask

    task automatic test_ghr_shift;
        lookup_valid = 1'b1;
        lookup_pc = 6'h1D;
        tick;
        n_cmp++;
        if (pred_ghr !== 4'b1011) begin
            n_fail++;
            $display("FAIL shift_taken: ghr=%b required 1011", pred_ghr);
        end
        lookup_pc = 6'h00;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_lookup: taken=%b required 0", pred_taken);
        end
        tick;
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if (pred_ghr !== 4'b0110) begin
            n_fail++;
            $display("FAIL shift_not_taken: ghr=%b required 0110", pred_ghr);
        end
    endtask

    task automatic test_no_bypass;
        lookup_valid = 1'b1;
        lookup_pc = 6'h3F;
        set_update(6'h39, 4'd0, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: taken=%b required 0", pred_taken);
        end
        tick;
        update_valid = 1'b0;
        lookup_valid = 1'b0;
        lookup_pc = 6'h35;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b1 || pred_ghr !== 4'b1100 || branch_count !== 16'd12) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: taken=%b ghr=%b bc=%0d required 1/1100/12", pred_taken, pred_ghr, branch_count);
        end
    endtask

    task automatic test_saturation;
        set_update(6'h25, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) tick;
        n_cmp++;
        if (branch_count !== 16'hFFFF || mispredict_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation: bc=%h mc=%h required FFFF/FFFF", branch_count, mispredict_count);
        end
        tick;
        n_cmp++;
        if (branch_count !== 16'hFFFF || mispredict_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation_hold: bc=%h mc=%h required FFFF/FFFF", branch_count, mispredict_count);
        end
    endtask

    task automatic test_midrun_reset;
        // update_valid is still high from the saturation run
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (branch_count !== 16'd0 || mispredict_count !== 16'd0 || pred_ghr !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: bc=%h mc=%h ghr=%b required 0/0/0", branch_count, mispredict_count, pred_ghr);
        end
        tick;
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 6'(i);
            #1;
            n_cmp++;
            if (pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pht pc=%0d: taken=%b required 0", i, pred_taken);
            end
        end
        n_cmp++;
        if (branch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_held: bc=%h required 0", branch_count);
        end
        update_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        lookup_pc = 6'h25;
        #1;
        n_cmp++;
        if (pred_taken !== 1'b0 || pred_ghr !== 4'd0 || branch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset: taken=%b ghr=%b bc=%h required 0/0/0", pred_taken, pred_ghr, branch_count);
        end
    endtask

`ifdef BPU_BTB_EN
    task automatic test_btb;
        update_target = 6'd3;
        set_update(6'd10, 4'd0, 1'b1, 1'b0);
        tick;
        update_valid = 1'b0;
        lookup_pc = 6'd10;
        #1;
        n_cmp++;
        if (pred_btb_hit !== 1'b1 || pred_target !== 6'd3) begin
            n_fail++;
            $display("FAIL btb_hit: hit=%b target=%0d required 1/3", pred_btb_hit, pred_target);
        end
        lookup_pc = 6'd18;
        #1;
        n_cmp++;
        if (pred_btb_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 6'd0) begin
            n_fail++;
            $display("FAIL btb_alias: hit=%b taken=%b target=%0d required 0/0/0", pred_btb_hit, pred_taken, pred_target);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef BPU_BTB_EN
        test_btb;
`else
        test_training;
        test_mispredict;
        test_stall;
        test_ghr_shift;
        test_no_bypass;
        test_saturation;
        test_midrun_reset;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor_unit.md
# branch_predictor_unit

Parametrised gshare branch prediction unit for the pipelined processor, replacing the fixed-size predictor.
- Fetch issues a lookup on the fetch PC and receives a taken/not-taken prediction plus a global-history snapshot.
- The snapshot travels down IF/ID with the instruction.
- Decode resolves the branch and returns the outcome, and the unit trains its tables from it.
- Adds over the fixed predictor: configurable table and history sizes, speculative history with misprediction recovery, saturating performance counters, and an optional BTB.

## Interface
Parameters:
- PC_W, 6, program-counter width in bits.
- IDX_W, 6, log2 of PHT entries; PHT index width.
- GHR_W, 4, global history length; 1 ≤ GHR_W ≤ IDX_W.
- CTR_W, 2, saturating counter width; ≥ 2.
- BTB_IDX_W, 3, log2 of BTB entries (used only with BPU_BTB_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freezes speculative history and lookup side effects.
- lookup_valid  in  1  fetch-stage lookup this cycle.
- lookup_pc  in  PC_W  fetch PC.
- pred_taken  out  1  predicted direction.
- pred_target  out  PC_W  predicted target (BTB); 0 when no BTB hit.
- pred_btb_hit  out  1  BTB tag match.
- pred_ghr  out  GHR_W  history snapshot used for this lookup; carried to decode.
- update_valid  in  1  decode resolved a conditional branch.
- update_pc  in  PC_W  PC of the resolved branch.
- update_ghr  in  GHR_W  snapshot returned from IF/ID.
- update_taken  in  1  actual direction.
- update_pred  in  1  direction that was predicted.
- update_target  in  PC_W  actual taken target.
- mispredict  out  1  update_valid & (update_taken != update_pred); combinational.
- branch_count  out  16  resolved branches, saturating.
- mispredict_count  out  16  mispredictions, saturating.

## Operation
PHT:
- 2^IDX_W entries of CTR_W-bit counters, held in a register array and read asynchronously.

Lookup index and prediction:
- Lookup index = lookup_pc[IDX_W-1:0] XOR zero-extend(ghr).
- lookup_pc is zero-extended when PC_W < IDX_W.
- pred_taken = counter MSB.
- With the BTB compiled in, the BTB gates pred_taken (see Configuration).
- pred_ghr = current speculative ghr.

Speculative history (ghr register):
- Mispredict has priority: ghr ← {update_ghr[GHR_W-2:0], update_taken}. For GHR_W = 1, ghr ← update_taken.
- Otherwise, when lookup_valid & ~stall & pred_taken-path-is-branch: ghr ← {ghr[GHR_W-2:0], pred_taken}.
  - "Is branch" means the BTB hit when the BTB is compiled in; otherwise it means lookup_valid.
- Otherwise ghr holds.

Training (update_valid, independent of stall):
- Update index = update_pc[IDX_W-1:0] XOR update_ghr.
- Counter increments on taken and decrements on not-taken.
- Counter saturates at 2^CTR_W-1 and at 0.

Performance counters:
- branch_count increments on each update_valid.
- mispredict_count increments on each mispredict.
- Both hold at 16'hFFFF.

Simultaneous lookup and update to the same index:
- The lookup sees the pre-update counter; there is no bypass.

## Timing
- Prediction outputs are combinational from lookup_pc and state; zero-cycle lookup latency.
- All state changes occur on the rising clk edge following the request. A trained counter is visible to lookups the next cycle.
- Recovery: the lookup in the cycle after mispredict uses the repaired ghr. The same-cycle lookup still uses the old ghr, and the pipeline flushes that lookup.
- Reset values, applied asynchronously on reset low and held while low:
  - ghr = 0.
  - Every PHT counter = 2^(CTR_W-1)-1, i.e. weakly not-taken; 01 for CTR_W = 2.
  - All BTB valid bits = 0.
  - branch_count = 0, mispredict_count = 0.
  - Outputs consequently reset to pred_taken = 0, pred_btb_hit = 0, pred_target = 0, pred_ghr = 0.
- Reset asserted mid-update discards the update; no partial writes.

## Configuration
Macro: BPU_BTB_EN.

Defined:
- Direct-mapped BTB with 2^BTB_IDX_W entries; each entry holds valid, tag = pc[PC_W-1:BTB_IDX_W], and a target.
- pred_btb_hit = valid & tag match.
- pred_taken = hit & counter MSB.
- pred_target = the entry's target when hit, else 0.
- On update_valid & update_taken: write {1, tag, update_target} to the entry.
- Not-taken updates leave the BTB unchanged.

Undefined:
- No BTB storage.
- pred_btb_hit = 0 and pred_target = 0.
- pred_taken = counter MSB; decode computes the target.
- ghr shifts on every non-stalled lookup_valid.

## Test plan
Default parameters throughout.
1. Reset: drive reset low mid-run -> ghr, counters and perf counts read 0; all PHT entries give pred_taken = 0; after release, lookup of any PC gives pred_taken = 0 and pred_ghr = 0.
2. Training: four taken updates for pc = 6'd5 with update_ghr = 0 -> counter goes 01→10→11→11 (saturates); lookup pc = 5 with ghr = 0 then gives pred_taken = 1; two not-taken updates return it to 01.
3. Mispredict recovery: ghr = 4'b1011, update_ghr = 4'b0110, update_taken = 1, update_pred = 0 -> mispredict = 1 in that cycle; next cycle ghr = 4'b1101, and mispredict_count increments.
4. Stall: stall = 1 with lookup_valid = 1 for 3 cycles -> ghr unchanged; a concurrent update_valid still trains its counter.
5. Saturation: 65540 mispredicting updates -> both branch_count and mispredict_count read 16'hFFFF and hold.
6. BTB (BPU_BTB_EN defined): taken update pc = 6'd10, target = 6'd3 -> next lookup pc = 10 gives pred_btb_hit = 1 and pred_target = 3; lookup pc = 6'd18 (same index, different tag) gives hit = 0, pred_taken = 0, pred_target = 0.
